// File: rtl/sm3_msg_arb.sv
// sm3_arb_fifo: small synchronous FIFO with wrapping pointers and an occupancy count.
// Latency: a pushed entry is visible at dout on the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module sm3_arb_fifo #(
    parameter int W   = 2,
    parameter int DEP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEP):0]   cnt
);
    localparam int AW = $clog2(DEP);

    logic [W-1:0]  mem [DEP];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEP));
    assign empty = (cnt == '0);
endmodule

// sm3_msg_arb: round-robin whole-message arbiter in front of one SM3 pipeline; routes digests back by grant order.
// Latency: granted beats pass combinationally; one bubble cycle per grant; digest leaves 1 cycle after cmprss_vld_i.
// Backpressure: dn_rdy_i goes straight to the granted requester; no grant while ID FIFO full. SM3_ARB_STAT_EN adds message counters.
module sm3_msg_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 32,
    parameter int ID_FIFO_DEP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ*DW-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]      req_vld_i,
    input  logic [NUM_REQ-1:0]      req_lst_i,
    output logic [NUM_REQ-1:0]      req_rdy_o,
    output logic [DW-1:0]           dn_data_o,
    output logic                    dn_vld_o,
    output logic                    dn_lst_o,
    input  logic                    dn_rdy_i,
    input  logic [255:0]            cmprss_res_i,
    input  logic                    cmprss_vld_i,
    output logic [255:0]            res_o,
    output logic [NUM_REQ-1:0]      res_vld_o,
    output logic                    busy_o,
    output logic                    err_o
`ifdef SM3_ARB_STAT_EN
    ,
    input  logic                    stat_clr_i,
    output logic [NUM_REQ*16-1:0]   stat_msg_cnt_o
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(ID_FIFO_DEP) + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  pick_id;
    logic            pick_vld;
    logic            grant;
    logic            msg_done;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IDW-1:0]  head_id;
    logic [CW-1:0]   fifo_cnt;

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_vld_i[j]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(j);
            end
        end
    end

    assign grant    = (state == IDLE) && pick_vld && !fifo_full;
    assign msg_done = (state == XFER) && req_vld_i[gnt_id] && req_lst_i[gnt_id] && dn_rdy_i;
    assign pop      = cmprss_vld_i && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)    state_nxt = XFER;
            XFER:    if (msg_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dn_vld_o  = 1'b0;
        dn_lst_o  = 1'b0;
        dn_data_o = '0;
        req_rdy_o = '0;
        if (state == XFER) begin
            dn_vld_o          = req_vld_i[gnt_id];
            dn_lst_o          = req_lst_i[gnt_id];
            dn_data_o         = req_data_i[gnt_id*DW +: DW];
            req_rdy_o[gnt_id] = dn_rdy_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant) gnt_id <= pick_id;
            if (msg_done) rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    sm3_arb_fifo #(
        .W   (IDW),
        .DEP (ID_FIFO_DEP)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (pop),
        .din   (pick_id),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    // A digest with nothing outstanding is dropped and flagged, never routed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_o     <= '0;
            res_vld_o <= '0;
            err_o     <= 1'b0;
        end else begin
            res_vld_o <= '0;
            if (pop) begin
                res_o     <= cmprss_res_i;
                res_vld_o <= NUM_REQ'(1) << head_id;
            end
            if (cmprss_vld_i && fifo_empty) err_o <= 1'b1;
        end
    end

    assign busy_o = (state == XFER) || (fifo_cnt != '0);

`ifdef SM3_ARB_STAT_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                     cnt_q <= '0;
            else if (stat_clr_i)                            cnt_q <= '0;
            else if (res_vld_o[k] && (cnt_q != 16'hFFFF))   cnt_q <= cnt_q + 16'd1;
        end
        assign stat_msg_cnt_o[k*16 +: 16] = cnt_q;
    end
`endif
endmodule

// File: tb/tb_sm3_msg_arb.sv
// Scoreboard bench for sm3_msg_arb: per-requester beat queues drive the ports, monitors pop expected beats and digests.
module tb_sm3_msg_arb;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;

    typedef struct packed {
        logic [2:0]  id;
        logic        lst;
        logic [31:0] dat;
    } beat_t;

    typedef struct packed {
        logic [2:0]   id;
        logic [255:0] dat;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_vld;
    logic [NR-1:0]     req_lst;
    logic [NR-1:0]     req_rdy;
    logic [DW-1:0]     dn_data;
    logic              dn_vld;
    logic              dn_lst;
    logic              dn_rdy;
    logic [255:0]      cmprss_res;
    logic              cmprss_vld;
    logic [255:0]      res;
    logic [NR-1:0]     res_vld;
    logic              busy;
    logic              err;
`ifdef SM3_ARB_STAT_EN
    logic              stat_clr;
    logic [NR*16-1:0]  stat_cnt;
`endif

    beat_t rq[NR][$];
    beat_t expq[$];
    res_t  resq[$];
    int    hs_log[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    msgs_done = 0;
    int    rdy_mode = 0;

    sm3_msg_arb #(.NUM_REQ(NR), .DW(DW), .ID_FIFO_DEP(DEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data_i   (req_data),
        .req_vld_i    (req_vld),
        .req_lst_i    (req_lst),
        .req_rdy_o    (req_rdy),
        .dn_data_o    (dn_data),
        .dn_vld_o     (dn_vld),
        .dn_lst_o     (dn_lst),
        .dn_rdy_i     (dn_rdy),
        .cmprss_res_i (cmprss_res),
        .cmprss_vld_i (cmprss_vld),
        .res_o        (res),
        .res_vld_o    (res_vld),
        .busy_o       (busy),
        .err_o        (err)
`ifdef SM3_ARB_STAT_EN
        ,
        .stat_clr_i     (stat_clr),
        .stat_msg_cnt_o (stat_cnt)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic beat_t mk(input int k, input int m, input int b, input int n);
        beat_t e;
        e.id  = 3'(k);
        e.lst = (b == n - 1);
        e.dat = 32'hA000_0000 | 32'(k << 16) | 32'(m << 8) | 32'(b);
        return e;
    endfunction

    task automatic load(input int k, input int m, input int n);
        for (int b = 0; b < n; b++) rq[k].push_back(mk(k, m, b, n));
    endtask

    task automatic expect_msg(input int k, input int m, input int n);
        for (int b = 0; b < n; b++) expq.push_back(mk(k, m, b, n));
    endtask

    function automatic logic [255:0] dg(input int n);
        return {8{32'hD1D1_0000 + 32'(n)}};
    endfunction

    task automatic drain(input int budget);
        int t = 0;
        while (expq.size() != 0 && t < budget) begin tick(); t++; end
        if (expq.size() != 0) fail("drain_timeout");
    endtask

    // id < 0 means no digest may be routed.
    task automatic digest(input logic [255:0] d, input int id);
        res_t r;
        cmprss_vld = 1'b1;
        cmprss_res = d;
        if (id >= 0) begin
            r.id  = 3'(id);
            r.dat = d;
            resq.push_back(r);
        end
        tick();
        cmprss_vld = 1'b0;
        chk("res_timing", res_vld, (id >= 0) ? (4'b1 << id) : 4'b0);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_outs"}, {dn_vld, dn_lst, dn_data, req_rdy, res_vld, busy, err}, '0);
        chk({tag, "_res"}, res, '0);
`ifdef SM3_ARB_STAT_EN
        chk({tag, "_stat"}, stat_cnt, '0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        rst_check(tag);
        for (int k = 0; k < NR; k++) rq[k].delete();
        expq.delete();
        resq.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Requester and downstream-ready driver: updates just after each rising edge.
    initial begin
        logic [NR-1:0] hs;
        req_vld  = '0;
        req_lst  = '0;
        req_data = '0;
        dn_rdy   = 1'b1;
        forever begin
            @(negedge clk);
            hs = req_vld & req_rdy;
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                if (rq[k].size() > 0) begin
                    req_vld[k]           = 1'b1;
                    req_lst[k]           = rq[k][0].lst;
                    req_data[k*DW +: DW] = rq[k][0].dat;
                end else begin
                    req_vld[k] = 1'b0;
                    req_lst[k] = 1'b0;
                end
            end
            dn_rdy = (rdy_mode == 1) ? ~dn_rdy : 1'b1;
        end
    end

    // Monitor: downstream beats and digest pulses against the expected queues.
    initial begin
        beat_t e;
        res_t  r;
        logic  prev_lst = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_lst = 1'b0;
            end else begin
                if (prev_lst) chk("bubble", dn_vld, 1'b0);
                prev_lst = 1'b0;
                if (dn_vld) begin
                    if (expq.size() == 0) begin
                        fail("beat_unexpected");
                    end else begin
                        e = expq[0];
                        chk("rdy_track", req_rdy, dn_rdy ? (4'b1 << e.id) : 4'b0);
                        if (dn_rdy) begin
                            chk("beat_dat", dn_data, e.dat);
                            chk("beat_lst", dn_lst, e.lst);
                            void'(expq.pop_front());
                            hs_log.push_back(cyc + 1);
                            if (e.lst) begin
                                prev_lst = 1'b1;
                                msgs_done++;
                            end
                        end
                    end
                end
                if (res_vld != '0) begin
                    if (resq.size() == 0) begin
                        fail("res_unexpected");
                    end else begin
                        r = resq.pop_front();
                        chk("res_vld", res_vld, 4'b1 << r.id);
                        chk("res_dat", res, r.dat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ids[5];
        int base;
        int sent;
        int t;
        int x;
        cmprss_vld = 1'b0;
        cmprss_res = '0;
`ifdef SM3_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1 rst_check("rst0");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Single 16-beat message from requester 1.
        load(1, 0, 16);
        expect_msg(1, 0, 16);
        drain(100);
        digest(dg(1), 1);
        tick();
        chk("t1_busy_idle", busy, 1'b0);
`ifdef SM3_ARB_STAT_EN
        chk("t1_stat", stat_cnt[16 +: 16], 16'd1);
`endif

        // Round-robin: all valid, pointer back at 0 after reset.
        do_reset("rst1");
        tick();
        base = msgs_done;
        hs_log.delete();
        load(0, 0, 2); load(0, 1, 2); load(1, 0, 2); load(2, 0, 2); load(3, 0, 2);
        expect_msg(0, 0, 2); expect_msg(1, 0, 2); expect_msg(2, 0, 2); expect_msg(3, 0, 2); expect_msg(0, 1, 2);
        ids = '{0, 1, 2, 3, 0};
        sent = 0;
        t = 0;
        while (sent < 5 && t < 200) begin
            if (msgs_done - base > sent) begin
                digest(dg(10 + sent), ids[sent]);
                sent++;
            end else begin
                tick();
            end
            t++;
        end
        if (sent < 5) fail("t2_digests");
        drain(20);
        if (hs_log.size() == 10) begin
            for (int i = 0; i < 4; i++) chk("t2_gap", hs_log[2*i+2] - hs_log[2*i+1], 2);
        end else begin
            fail("t2_beat_count");
        end

        // Back-pressure on requester 2 while requester 3 waits.
        rdy_mode = 1;
        load(2, 0, 8); load(3, 1, 2);
        expect_msg(2, 0, 8); expect_msg(3, 1, 2);
        drain(100);
        rdy_mode = 0;
        digest(dg(20), 2);
        digest(dg(21), 3);
        tick();

        // FIFO full: fifth grant held until a digest frees a slot.
        hs_log.delete();
        load(0, 5, 1); load(1, 5, 1); load(2, 5, 1); load(3, 5, 1); load(0, 6, 1);
        expect_msg(0, 5, 1); expect_msg(1, 5, 1); expect_msg(2, 5, 1); expect_msg(3, 5, 1); expect_msg(0, 6, 1);
        t = 0;
        while (expq.size() > 1 && t < 100) begin tick(); t++; end
        repeat (6) tick();
        chk("t4_no_grant", expq.size(), 1);
        chk("t4_dn_idle", {dn_vld, req_rdy}, '0);
        chk("t4_busy", busy, 1'b1);
        x = cyc;
        digest(dg(30), 0);
        drain(20);
        chk("t4_resume", hs_log[hs_log.size()-1], x + 3);
        digest(dg(31), 1);
        digest(dg(32), 2);
        digest(dg(33), 3);
        digest(dg(34), 0);
        tick();
        chk("t4_busy_clear", busy, 1'b0);

        // Digest with nothing outstanding, then push and pop in one cycle.
        digest(dg(40), -1);
        chk("t5_err", err, 1'b1);
        repeat (3) tick();
        chk("t5_err_sticky", err, 1'b1);
        load(1, 7, 1);
        expect_msg(1, 7, 1);
        drain(20);
        chk("t5_busy_pending", busy, 1'b1);
        load(2, 7, 1);
        expect_msg(2, 7, 1);
        tick();
        x = cyc;
        digest(dg(41), 1);
        drain(20);
        chk("t5_same_cycle_grant", hs_log[hs_log.size()-1], x + 2);
        tick();
        chk("t5_cnt_kept", busy, 1'b1);
        digest(dg(42), 2);
        tick();
        chk("t5_busy_clear", busy, 1'b0);

        // Reset at beat 5 of a requester-3 message.
        load(3, 8, 16);
        expect_msg(3, 8, 16);
        t = 0;
        while (expq.size() > 12 && t < 100) begin tick(); t++; end
        chk("t6_beats_before_rst", expq.size(), 12);
        do_reset("rst6");
        tick();
        load(1, 9, 1); load(3, 9, 1);
        expect_msg(1, 9, 1); expect_msg(3, 9, 1);
        drain(20);
        digest(dg(50), 1);
        digest(dg(51), 3);
        tick();

        chk("end_expq", expq.size(), 0);
        chk("end_resq", resq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
